// File: rtl/video_pkg.sv
// video_pkg: shared raster widths, 480p timing defaults and the sync bus type
package video_pkg;
    localparam int VIDEO_X_BITWIDTH = 10;
    localparam int VIDEO_Y_BITWIDTH = 10;
    localparam int H_ACTIVE_480P    = 720;
    localparam int H_FP_480P        = 16;
    localparam int H_SYNC_480P      = 62;
    localparam int H_BP_480P        = 60;
    localparam int V_ACTIVE_480P    = 480;
    localparam int V_FP_480P        = 9;
    localparam int V_SYNC_480P      = 6;
    localparam int V_BP_480P        = 30;
    typedef struct packed {
        logic de;
        logic hsync;
        logic vsync;
    } sync_bus_t;
endpackage

// File: rtl/video_timing_gen_sync_delay.sv
// sync_delay: PIPE_DELAY-stage shift register for the {de,hsync,vsync} bus
// Ports: clk clock; rst_n async active-low reset (stages load RST_VAL);
//        d_i bus in; q_o bus delayed by PIPE_DELAY clocks.
module sync_delay
    import video_pkg::*;
#(
    parameter int        PIPE_DELAY = 1,
    parameter sync_bus_t RST_VAL    = '0
) (
    input  logic      clk,
    input  logic      rst_n,
    input  sync_bus_t d_i,
    output sync_bus_t q_o
);
    sync_bus_t stage_q [PIPE_DELAY];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < PIPE_DELAY; i++) stage_q[i] <= RST_VAL;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < PIPE_DELAY; i++) stage_q[i] <= stage_q[i-1];
        end
    end
    assign q_o = stage_q[PIPE_DELAY-1];
endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen: free-running 720x480p raster timing generator
// Ports: clk pixel clock; rst async active-low reset; x/y raster counts;
//        de/hsync/vsync aligned with x/y; frame_start one-clock pulse at (0,0);
//        de_d/hsync_d/vsync_d the flags delayed by PIPE_DELAY clocks;
//        frame_cnt frames seen since reset, present only when VTG_FRAME_COUNTER_EN is defined.
module video_timing_gen
    import video_pkg::*;
#(
    parameter int   H_ACTIVE   = H_ACTIVE_480P,
    parameter int   H_FP       = H_FP_480P,
    parameter int   H_SYNC     = H_SYNC_480P,
    parameter int   H_BP       = H_BP_480P,
    parameter int   V_ACTIVE   = V_ACTIVE_480P,
    parameter int   V_FP       = V_FP_480P,
    parameter int   V_SYNC     = V_SYNC_480P,
    parameter int   V_BP       = V_BP_480P,
    parameter logic SYNC_POL   = 1'b0,
    parameter int   PIPE_DELAY = 1
`ifdef VTG_FRAME_COUNTER_EN
    ,
    parameter int   FRAME_CNT_W = 8
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [VIDEO_X_BITWIDTH-1:0] x,
    output logic [VIDEO_Y_BITWIDTH-1:0] y,
    output logic                        de,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        frame_start,
    output logic                        de_d,
    output logic                        hsync_d,
    output logic                        vsync_d
`ifdef VTG_FRAME_COUNTER_EN
    ,
    output logic [FRAME_CNT_W-1:0]      frame_cnt
`endif
);
    localparam int XW      = VIDEO_X_BITWIDTH;
    localparam int YW      = VIDEO_Y_BITWIDTH;
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [XW-1:0] X_LAST   = XW'(H_TOTAL - 1);
    localparam logic [XW-1:0] X_ONE    = XW'(1);
    localparam logic [XW-1:0] X_DE_END = XW'(H_ACTIVE);
    localparam logic [XW-1:0] X_HS_BEG = XW'(H_ACTIVE + H_FP);
    localparam logic [XW-1:0] X_HS_END = XW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [YW-1:0] Y_LAST   = YW'(V_TOTAL - 1);
    localparam logic [YW-1:0] Y_ONE    = YW'(1);
    localparam logic [YW-1:0] Y_DE_END = YW'(V_ACTIVE);
    localparam logic [YW-1:0] Y_VS_BEG = YW'(V_ACTIVE + V_FP);
    localparam logic [YW-1:0] Y_VS_END = YW'(V_ACTIVE + V_FP + V_SYNC);
    localparam sync_bus_t IDLE = '{de: 1'b0, hsync: ~SYNC_POL, vsync: ~SYNC_POL};

    if (2 ** XW < H_TOTAL) begin : g_x_width_check
        $error("VIDEO_X_BITWIDTH too narrow for H_TOTAL");
    end
    if (2 ** YW < V_TOTAL) begin : g_y_width_check
        $error("VIDEO_Y_BITWIDTH too narrow for V_TOTAL");
    end
    if (PIPE_DELAY < 1 || PIPE_DELAY > 4) begin : g_delay_check
        $error("PIPE_DELAY must be 1..4");
    end

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    sync_bus_t     flags_q, flags_d, delayed;
    logic          frame_start_q, frame_start_d;

    // Flags are decoded from the next counts so the registered flags line up with x/y.
    always_comb begin
        x_d           = (x_q == X_LAST) ? '0 : x_q + X_ONE;
        y_d           = (x_q != X_LAST) ? y_q : (y_q == Y_LAST) ? '0 : y_q + Y_ONE;
        flags_d.de    = (x_d < X_DE_END) && (y_d < Y_DE_END);
        flags_d.hsync = (x_d >= X_HS_BEG && x_d < X_HS_END) ? SYNC_POL : ~SYNC_POL;
        flags_d.vsync = (y_d >= Y_VS_BEG && y_d < Y_VS_END) ? SYNC_POL : ~SYNC_POL;
        frame_start_d = (x_d == '0) && (y_d == '0);
    end

    // Reset parks the raster on the last back-porch pixel so the first clock lands on (0,0).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q           <= X_LAST;
            y_q           <= Y_LAST;
            flags_q       <= IDLE;
            frame_start_q <= 1'b0;
        end else begin
            x_q           <= x_d;
            y_q           <= y_d;
            flags_q       <= flags_d;
            frame_start_q <= frame_start_d;
        end
    end

    sync_delay #(
        .PIPE_DELAY(PIPE_DELAY),
        .RST_VAL   (IDLE)
    ) u_sync_delay (
        .clk  (clk),
        .rst_n(rst),
        .d_i  (flags_q),
        .q_o  (delayed)
    );

    assign x           = x_q;
    assign y           = y_q;
    assign de          = flags_q.de;
    assign hsync       = flags_q.hsync;
    assign vsync       = flags_q.vsync;
    assign frame_start = frame_start_q;
    assign de_d        = delayed.de;
    assign hsync_d     = delayed.hsync;
    assign vsync_d     = delayed.vsync;

`ifdef VTG_FRAME_COUNTER_EN
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    // Counts on the same edge that raises frame_start, so frame one reads 1.
    always_comb frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(frame_start_d);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) frame_cnt_q <= '0;
        else      frame_cnt_q <= frame_cnt_d;
    end
    assign frame_cnt = frame_cnt_q;
`endif
endmodule
